// File: rtl/ps_capture.sv
// Camera capture: samples the 8-bit camera bus and packs byte pairs into RGB444 pixels.
// Optional colour-bar replacement of pixel data when TEST_PATTERN_EN is defined.
module ps_capture #(
  parameter int SKIP_FRAMES = 2,
  parameter int H_ACTIVE    = 640,
  parameter int CNT_W       = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cfg_done,
  input  logic        i_vsync,
  input  logic        i_href,
  input  logic [7:0]  i_data,
  output logic [11:0] o_data,
  output logic        o_valid,
  output logic        o_sof,
  output logic        o_frame_done,
  output logic        o_line_err
);

  localparam int SKIP_W =
    (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);

  localparam logic [SKIP_W-1:0] SKIP_INIT =
    SKIP_W'(SKIP_FRAMES);

  localparam logic [CNT_W-1:0] H_CNT =
    CNT_W'(H_ACTIVE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;

  logic              vs_q;
  logic              vs_qq;
  logic              hr_q;
  logic              hr_qq;
  logic [7:0]        d_q;

  logic [1:0]        state;
  logic [1:0]        state_n;
  logic [SKIP_W-1:0] skip_cnt;
  logic [SKIP_W-1:0] skip_n;
  logic              phase;
  logic              phase_n;
  logic [3:0]        r_nib;
  logic [3:0]        r_n;
  logic [CNT_W-1:0]  pix_cnt;
  logic [CNT_W-1:0]  pix_n;
  logic              ovf;
  logic              ovf_n;
  logic              sof_pend;
  logic              sof_pend_n;

  logic [11:0]       pix_data;
  logic [11:0]       data_n;
  logic              valid_n;
  logic              sof_n;
  logic              done_n;
  logic              err_n;

  logic              vs_rise;
  logic              vs_fall;
  logic              hr_fall;
  logic              pix_max;

  assign vs_rise = vs_q & ~vs_qq;
  assign vs_fall = ~vs_q & vs_qq;
  assign hr_fall = ~hr_q & hr_qq;
  assign pix_max = &pix_cnt;

`ifdef TEST_PATTERN_EN
  localparam int BAR_W =
    (H_ACTIVE < 8) ? 1 : H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] BAR_DIV =
    CNT_W'(BAR_W);

  logic [CNT_W-1:0] bar_idx;

  always_comb begin
    bar_idx  = pix_cnt / BAR_DIV;
    pix_data = 12'h000;
    unique case (1'b1)
      (bar_idx == CNT_W'(0)): pix_data = 12'hFFF;
      (bar_idx == CNT_W'(1)): pix_data = 12'hFF0;
      (bar_idx == CNT_W'(2)): pix_data = 12'h0FF;
      (bar_idx == CNT_W'(3)): pix_data = 12'h0F0;
      (bar_idx == CNT_W'(4)): pix_data = 12'hF0F;
      (bar_idx == CNT_W'(5)): pix_data = 12'hF00;
      (bar_idx == CNT_W'(6)): pix_data = 12'h00F;
      default:                pix_data = 12'h000;
    endcase
  end
`else
  always_comb begin
    pix_data = {r_nib, d_q};
  end
`endif

  always_comb begin
    state_n    = state;
    skip_n     = skip_cnt;
    phase_n    = phase;
    r_n        = r_nib;
    pix_n      = pix_cnt;
    ovf_n      = ovf;
    sof_pend_n = sof_pend;
    data_n     = o_data;
    valid_n    = 1'b0;
    sof_n      = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;

    if (!i_cfg_done) begin
      // config lost: drop any half-built pixel silently
      state_n    = S_IDLE;
      phase_n    = 1'b0;
      pix_n      = '0;
      ovf_n      = 1'b0;
      sof_pend_n = 1'b0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          state_n = S_WAIT;
          skip_n  = SKIP_INIT;
        end
        (state == S_WAIT): begin
          if (vs_fall) begin
            if (skip_cnt == '0) begin
              state_n    = S_CAP;
              sof_pend_n = 1'b1;
              phase_n    = 1'b0;
              pix_n      = '0;
              ovf_n      = 1'b0;
            end else begin
              skip_n = skip_cnt - SKIP_W'(1);
            end
          end
        end
        (state == S_CAP): begin
          if (vs_rise) begin
            // a line still open here was cut short
            state_n    = S_WAIT;
            done_n     = 1'b1;
            err_n      = hr_q;
            phase_n    = 1'b0;
            pix_n      = '0;
            ovf_n      = 1'b0;
            sof_pend_n = 1'b0;
          end else if (hr_q) begin
            if (!phase) begin
              r_n     = d_q[3:0];
              phase_n = 1'b1;
            end else begin
              phase_n    = 1'b0;
              valid_n    = 1'b1;
              data_n     = pix_data;
              sof_n      = sof_pend;
              sof_pend_n = 1'b0;
              if (pix_max) begin
                ovf_n = 1'b1;
              end else begin
                pix_n = pix_cnt + CNT_W'(1);
              end
            end
          end else if (hr_fall) begin
            err_n   = phase | ovf | (pix_cnt != H_CNT);
            phase_n = 1'b0;
            pix_n   = '0;
            ovf_n   = 1'b0;
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vs_q         <= 1'b0;
      vs_qq        <= 1'b0;
      hr_q         <= 1'b0;
      hr_qq        <= 1'b0;
      d_q          <= '0;
      state        <= S_IDLE;
      skip_cnt     <= '0;
      phase        <= 1'b0;
      r_nib        <= '0;
      pix_cnt      <= '0;
      ovf          <= 1'b0;
      sof_pend     <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_sof        <= 1'b0;
      o_frame_done <= 1'b0;
      o_line_err   <= 1'b0;
    end else begin
      vs_q         <= i_vsync;
      vs_qq        <= vs_q;
      hr_q         <= i_href;
      hr_qq        <= hr_q;
      d_q          <= i_data;
      state        <= state_n;
      skip_cnt     <= skip_n;
      phase        <= phase_n;
      r_nib        <= r_n;
      pix_cnt      <= pix_n;
      ovf          <= ovf_n;
      sof_pend     <= sof_pend_n;
      o_data       <= data_n;
      o_valid      <= valid_n;
      o_sof        <= sof_n;
      o_frame_done <= done_n;
      o_line_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_ps_capture.sv
// Directed bench for ps_capture: skip, packing, line checks, config drop, reset.
// Build with TEST_PATTERN_EN defined to check colour bars instead of camera data.
module tb_ps_capture;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_cfg_done;
  logic        i_vsync;
  logic        i_href;
  logic [7:0]  i_data;
  logic [11:0] o_data;
  logic        o_valid;
  logic        o_sof;
  logic        o_frame_done;
  logic        o_line_err;

`ifdef TEST_PATTERN_EN
  localparam bit TP_EN = 1'b1;
`else
  localparam bit TP_EN = 1'b0;
`endif

  always #5 i_clk = ~i_clk;

  ps_capture dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_cfg_done(i_cfg_done),
    .i_vsync(i_vsync),
    .i_href(i_href),
    .i_data(i_data),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_sof(o_sof),
    .o_frame_done(o_frame_done),
    .o_line_err(o_line_err)
  );

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [11:0] exp;
  } pack_t;

  typedef struct {
    int nbytes;
    int exp_pix;
    int exp_err;
  } line_t;

  int nvec = 0;
  int nmis = 0;
  int nvalid = 0;
  int nsof = 0;
  int ndone = 0;
  int nlerr = 0;
  int nsame = 0;
  int sof_bad = 0;
  logic [11:0] q[$];

  always @(posedge i_clk) begin
    #1;
    if (o_valid) begin
      nvalid++;
      q.push_back(o_data);
    end
    if (o_sof) begin
      nsof++;
      if (!o_valid) sof_bad++;
    end
    if (o_frame_done) ndone++;
    if (o_line_err) nlerr++;
    if (o_frame_done && o_line_err) nsame++;
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  function automatic logic [11:0] cam_px(input int p);
    return 12'((p * 37 + 5) % 4096);
  endfunction

  function automatic logic [11:0] exp_px(input int idx,
                                         input logic [11:0] cam);
    int b;
    logic [11:0] bar;
    b = idx / 80;
    if (b > 7) b = 7;
    case (b)
      0: bar = 12'hFFF;
      1: bar = 12'hFF0;
      2: bar = 12'h0FF;
      3: bar = 12'h0F0;
      4: bar = 12'hF0F;
      5: bar = 12'hF00;
      6: bar = 12'h00F;
      default: bar = 12'h000;
    endcase
    return TP_EN ? bar : cam;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_href = 1'b1;
    i_data = b;
    tick(1);
  endtask

  task automatic line_end();
    i_href = 1'b0;
    i_data = 8'h00;
    tick(4);
  endtask

  task automatic send_line(input int n);
    logic [11:0] c;
    for (int i = 0; i < n; i++) begin
      c = cam_px(i / 2);
      if (i % 2 == 0) send_byte({4'hA, c[11:8]});
      else            send_byte(c[7:0]);
    end
    line_end();
  endtask

  task automatic frame_begin();
    i_vsync = 1'b0;
    tick(4);
  endtask

  task automatic frame_end();
    i_href  = 1'b0;
    i_vsync = 1'b1;
    tick(6);
  endtask

  pack_t pk[6];
  line_t ln[7];

  initial begin
    int v0;
    int s0;
    int d0;
    int e0;
    int m0;
    int bad;
    bit found;

    pk[0] = '{8'h0A, 8'h5C, 12'hA5C};
    pk[1] = '{8'hFF, 8'h00, 12'hF00};
    pk[2] = '{8'h30, 8'hFF, 12'h0FF};
    pk[3] = '{8'hC7, 8'h12, 12'h712};
    pk[4] = '{8'h05, 8'hA5, 12'h5A5};
    pk[5] = '{8'h9E, 8'h00, 12'hE00};

    ln[0] = '{1280,  640, 0};
    ln[1] = '{1279,  639, 1};
    ln[2] = '{1280,  640, 0};
    ln[3] = '{1278,  639, 1};
    ln[4] = '{2,       1, 1};
    ln[5] = '{1282,  641, 1};
    ln[6] = '{2050, 1025, 1};

    i_rst      = 1'b1;
    i_cfg_done = 1'b0;
    i_vsync    = 1'b1;
    i_href     = 1'b0;
    i_data     = 8'h00;
    tick(3);
    chk("rst_data",  o_data, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_sof",   o_sof, 0);
    chk("rst_done",  o_frame_done, 0);
    chk("rst_err",   o_line_err, 0);
    i_rst = 1'b0;
    tick(2);

    // camera running before configuration finishes
    v0 = nvalid;
    frame_begin();
    send_line(40);
    frame_end();
    chk("precfg_valid", nvalid - v0, 0);

    i_cfg_done = 1'b1;
    tick(3);
    for (int f = 0; f < 4; f++) begin
      v0 = nvalid; s0 = nsof; d0 = ndone; e0 = nlerr;
      frame_begin();
      send_line(1280);
      send_line(1280);
      frame_end();
      chk($sformatf("skip_f%0d_valid", f), nvalid - v0, (f < 2) ? 0 : 1280);
      chk($sformatf("skip_f%0d_sof", f),   nsof - s0,   (f < 2) ? 0 : 1);
      chk($sformatf("skip_f%0d_done", f),  ndone - d0,  (f < 2) ? 0 : 1);
      chk($sformatf("skip_f%0d_err", f),   nlerr - e0,  0);
    end

    // packing and latency
    e0 = nlerr; d0 = ndone;
    frame_begin();
    q.delete();
    for (int i = 0; i < 6; i++) begin
      send_byte(pk[i].b0);
      if (i == 1) begin
        chk("lat_valid_2cyc", o_valid, 1);
        chk("lat_data", o_data, exp_px(0, 12'hA5C));
        chk("lat_sof", o_sof, 1);
      end
      send_byte(pk[i].b1);
      if (i == 0) chk("lat_valid_1cyc", o_valid, 0);
      if (i == 1) begin
        chk("hold_valid", o_valid, 0);
        chk("hold_data", o_data, exp_px(0, 12'hA5C));
      end
    end
    line_end();
    chk("pack_count", q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < q.size())
        chk($sformatf("pack_%0d", i), q[i], exp_px(i, pk[i].exp));
    end
    chk("pack_line_err", nlerr - e0, 1);
    frame_end();
    chk("pack_done", ndone - d0, 1);

    // line-length table
    frame_begin();
    for (int k = 0; k < 7; k++) begin
      v0 = nvalid; e0 = nlerr;
      q.delete();
      send_line(ln[k].nbytes);
      chk($sformatf("line%0d_pix", k), nvalid - v0, ln[k].exp_pix);
      chk($sformatf("line%0d_err", k), nlerr - e0, ln[k].exp_err);
      bad = 0;
      for (int i = 0; i < q.size(); i++) begin
        if (q[i] !== exp_px(i, cam_px(i))) begin
          if (bad == 0)
            $display("line%0d pixel %0d: got %h want %h",
                     k, i, q[i], exp_px(i, cam_px(i)));
          bad++;
        end
      end
      chk($sformatf("line%0d_data", k), bad, 0);
    end
    frame_end();

    // config dropped mid-line
    d0 = ndone; e0 = nlerr;
    frame_begin();
    for (int i = 0; i < 600; i++) send_byte(8'h11);
    i_cfg_done = 1'b0;
    m0 = nvalid;
    for (int i = 0; i < 20; i++) send_byte(8'h22);
    chk("drop_valid_stop", (nvalid - m0 <= 1) ? 1 : 0, 1);
    line_end();
    frame_end();
    chk("drop_no_done", ndone - d0, 0);
    chk("drop_no_err", nlerr - e0, 0);
    i_cfg_done = 1'b1;
    tick(3);
    for (int f = 0; f < 3; f++) begin
      v0 = nvalid;
      frame_begin();
      send_line(1280);
      frame_end();
      chk($sformatf("reskip_f%0d", f), nvalid - v0, (f < 2) ? 0 : 640);
    end

    // vsync rises while href is still high
    d0 = ndone; e0 = nlerr; m0 = nsame;
    frame_begin();
    for (int i = 0; i < 100; i++) send_byte(8'h33);
    i_vsync = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'h44);
    line_end();
    tick(4);
    chk("trunc_done", ndone - d0, 1);
    chk("trunc_err", nlerr - e0, 1);
    chk("trunc_same_cycle", nsame - m0, 1);

    // asynchronous reset mid-line
    frame_begin();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send_byte(8'h55);
      if (o_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_find_valid", found, 1);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_data",  o_data, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_sof",   o_sof, 0);
    chk("arst_done",  o_frame_done, 0);
    chk("arst_err",   o_line_err, 0);
    tick(2);
    i_rst = 1'b0;
    v0 = nvalid;
    for (int i = 0; i < 10; i++) send_byte(8'h66);
    line_end();
    frame_end();
    frame_begin();
    send_line(40);
    frame_end();
    chk("post_rst_skip", nvalid - v0, 0);

    chk("sof_without_valid", sof_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
